adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, master AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, master AXI4-Lite data width (only 32 supported).
REQ-003 SHALL have parameter C_ADDER_BASEADDR, default 32'h0000_0000, adder peripheral base address.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 ACLK  in  1  clock.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 op_valid, op_ready  in/out  1  operand-pair handshake.
REQ-008 op_a, op_b  in  32  operands.
REQ-009 res_valid, res_ready  out/in  1  result handshake.
REQ-010 res_data  out  32  sum read back; res_err  out  1  bus error flag.
REQ-011 busy  out  1  job in flight; job_cnt  out  16  completed jobs.
REQ-012 M_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master: AWADDR, AWPROT(3), AWVALID/AWREADY, WDATA, WSTRB(4), WVALID/WREADY, BRESP(2), BVALID/BREADY, ARADDR, ARPROT(3), ARVALID/ARREADY, RDATA, RRESP(2), RVALID/RREADY.

Function
REQ-013 Register map: base+0x0 operand A, base+0x4 operand B, base+0x8 result (A+B mod 2^32).
REQ-014 States IDLE -> WR_A -> WR_B -> RD_RES -> RESP -> IDLE.
REQ-015 IDLE: op_ready=1; op_valid&op_ready captures op_a/op_b, next state WR_A.
REQ-016 WR_x entry: AWVALID and WVALID assert together next cycle; AWPROT=0, WSTRB=4'hF.
REQ-017 AWVALID and WVALID each drop the cycle after its own handshake, independently; address/data held stable while valid.
REQ-018 BREADY=1 only after both AW and W handshakes done; state advances on B handshake.
REQ-019 RD_RES: ARVALID asserts with ARADDR=base+0x8, ARPROT=0; drops after AR handshake; RREADY=1 after AR handshake; capture RDATA on R handshake.
REQ-020 Non-OKAY BRESP in WR_A/WR_B: remaining transfers skipped, go RESP with res_err=1, res_data=0.
REQ-021 Non-OKAY RRESP: go RESP with res_err=1, res_data=RDATA.
REQ-022 RESP: res_valid=1, held with data stable until res_ready; on handshake job_cnt+1 (only if res_err=0), return IDLE.
REQ-023 job_cnt wraps 16'hFFFF -> 0.
REQ-024 busy=1 in every state except IDLE.
REQ-025 Only one AXI transaction outstanding; no AXI valid asserted in IDLE or RESP.
REQ-026 Minimum job latency, zero-wait slave with AWREADY/WREADY/ARREADY=1 and B/R returned next cycle: op handshake to res_valid = 7 cycles.
REQ-027 Op accepted in same cycle as RESP handshake: not allowed; op_ready=0 outside IDLE.

Reset
REQ-028 ARESETN low: state IDLE, all AXI valids/readies 0, res_valid 0, res_data 0, res_err 0, job_cnt 0, busy 0; op_ready=1 first cycle after deassertion.
REQ-029 Reset mid-transaction aborts immediately; no AXI valid reasserted until new op.

Structure
REQ-030 Package adder_seq_pkg holds state enum, register offsets (A_OFS, B_OFS, RES_OFS), AXI resp constant OKAY=2'b00.
REQ-031 Sub-module axil_single_xfer (one AXI4-Lite write or read per request, resp returned) is natural; FSM sequences it.

Verification
REQ-032 Ops A=1,B=2, zero-wait VIP slave -> writes 0x0=1, 0x4=2, read 0x8, res_data=3, res_err=0, job_cnt=1, latency 7.
REQ-033 A=32'hFFFF_FFFF,B=2 -> res_data=1 (wrap), res_err=0.
REQ-034 Slave delays AWREADY 3 cycles, WREADY 0 -> WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, BREADY only after both.
REQ-035 BRESP=SLVERR on WR_A -> no WR_B, no AR, res_err=1, res_data=0, job_cnt unchanged.
REQ-036 res_ready held low 10 cycles -> res_valid/res_data stable, op_ready=0 throughout.
REQ-037 ARESETN pulsed low during WR_B with AWVALID=1 -> all outputs reset values next cycle, new op A=5,B=6 -> res_data=11.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the adder sequencer: controller state encoding,
// register offsets of the adder peripheral and the AXI OKAY response code.
// -----------------------------------------------------------------------------
package adder_seq_pkg;

    // Controller states: write A, write B, read the sum, present the result.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_A   = 3'd1,
        WR_B   = 3'd2,
        RD_RES = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Byte offsets of the adder peripheral registers from its base address.
    localparam logic [7:0] A_OFS   = 8'h00;
    localparam logic [7:0] B_OFS   = 8'h04;
    localparam logic [7:0] RES_OFS = 8'h08;

    // AXI response code for a successful transfer.
    localparam logic [1:0] OKAY = 2'b00;

endpackage : adder_seq_pkg

// File: rtl/axil_single_xfer.sv
// -----------------------------------------------------------------------------
// axil_single_xfer
// Performs one AXI4-Lite write or read per start strobe and reports its
// completion and response.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request; accepted only when idle
//   is_write              1 = write (addr/wdata), 0 = read (addr)
//   addr, wdata           transfer address and write data
//   done                  B or R handshake happening this cycle
//   resp, rdata           BRESP/RRESP of the finishing transfer, RDATA
//   m_axi_*               AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_single_xfer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    logic wr_phase;   // a write is in flight (until its B handshake)
    logic rd_phase;   // a read is in flight (until its R handshake)

    logic b_fire;
    logic r_fire;
    logic aw_pending; // address still waiting for AWREADY after this cycle
    logic w_pending;
    logic ar_pending;

    assign b_fire     = m_axi_bvalid && m_axi_bready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign aw_pending = m_axi_awvalid && !m_axi_awready;
    assign w_pending  = m_axi_wvalid && !m_axi_wready;
    assign ar_pending = m_axi_arvalid && !m_axi_arready;

    assign done  = b_fire || r_fire;
    assign resp  = r_fire ? m_axi_rresp : m_axi_bresp;
    assign rdata = m_axi_rdata;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_phase      <= 1'b0;
            rd_phase      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            // AW and W retire independently, each on its own handshake.
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;

            // Accept the response only once both address and data are gone.
            if (b_fire) begin
                m_axi_bready <= 1'b0;
                wr_phase     <= 1'b0;
            end else if (wr_phase && !aw_pending && !w_pending) begin
                m_axi_bready <= 1'b1;
            end

            if (r_fire) begin
                m_axi_rready <= 1'b0;
                rd_phase     <= 1'b0;
            end else if (rd_phase && !ar_pending) begin
                m_axi_rready <= 1'b1;
            end

            // A new request may land on the edge that completes the previous
            // one, so it is applied last and overrides the completion above.
            if (start) begin
                if (is_write) begin
                    m_axi_awaddr  <= addr;
                    m_axi_wdata   <= wdata;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    wr_phase      <= 1'b1;
                end else begin
                    m_axi_araddr  <= addr;
                    m_axi_arvalid <= 1'b1;
                    rd_phase      <= 1'b1;
                end
            end
        end
    end

endmodule : axil_single_xfer

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
// Accepts an operand pair, writes it to a memory-mapped adder over AXI4-Lite,
// reads back the sum and hands it out on a valid/ready result port.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   op_valid/op_ready      operand handshake, op_a/op_b operands
//   res_valid/res_ready    result handshake, res_data sum, res_err bus error
//   busy                   job in flight
//   job_cnt                successfully completed jobs (wraps)
//   M_AXI_*                AXI4-Lite master towards the adder peripheral
// -----------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDER_BASEADDR   = 32'h0000_0000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [31:0]                   op_a,
    input  logic [31:0]                   op_b,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [31:0]                   res_data,
    output logic                          res_err,
    output logic                          busy,
    output logic [15:0]                   job_cnt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    localparam logic [AW-1:0] ADDR_A   = C_ADDER_BASEADDR + AW'(A_OFS);
    localparam logic [AW-1:0] ADDR_B   = C_ADDER_BASEADDR + AW'(B_OFS);
    localparam logic [AW-1:0] ADDR_RES = C_ADDER_BASEADDR + AW'(RES_OFS);

    state_t                        state;
    logic [31:0]                   b_q;   // operand B, needed one transfer later

    logic                          xfer_start;
    logic                          xfer_write;
    logic [AW-1:0]                 xfer_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] xfer_wdata;
    logic                          xfer_done;
    logic [1:0]                    xfer_resp;
    logic [C_M_AXI_DATA_WIDTH-1:0] xfer_rdata;
    logic                          xfer_ok;

    assign xfer_ok = xfer_done && (xfer_resp == OKAY);

    // Launch the next transfer on the same edge the previous one completes,
    // so a zero-wait slave sees back-to-back transactions.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        xfer_start = 1'b0;
        xfer_write = 1'b1;
        xfer_addr  = ADDR_A;
        xfer_wdata = op_a;
        case (state)
            IDLE: begin
                if (op_valid && op_ready) xfer_start = 1'b1;
            end
            WR_A: begin
                if (xfer_ok) begin
                    xfer_start = 1'b1;
                    xfer_addr  = ADDR_B;
                    xfer_wdata = b_q;
                end
            end
            WR_B: begin
                if (xfer_ok) begin
                    xfer_start = 1'b1;
                    xfer_write = 1'b0;
                    xfer_addr  = ADDR_RES;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            b_q       <= '0;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            job_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        b_q      <= op_b;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        res_err  <= 1'b0;
                        res_data <= '0;
                        state    <= WR_A;
                    end
                end
                WR_A, WR_B: begin
                    if (xfer_done) begin
                        if (xfer_resp == OKAY) begin
                            state <= (state == WR_A) ? WR_B : RD_RES;
                        end else begin
                            // Failed write: skip the rest of the job.
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_data  <= '0;
                            state     <= RESP;
                        end
                    end
                end
                RD_RES: begin
                    if (xfer_done) begin
                        res_valid <= 1'b1;
                        res_data  <= xfer_rdata;
                        res_err   <= (xfer_resp != OKAY);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                        if (!res_err) job_cnt <= job_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    axil_single_xfer #(
        .ADDR_W (AW),
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_xfer (
        .clk           (ACLK),
        .rst_n         (ARESETN),
        .start         (xfer_start),
        .is_write      (xfer_write),
        .addr          (xfer_addr),
        .wdata         (xfer_wdata),
        .done          (xfer_done),
        .resp          (xfer_resp),
        .rdata         (xfer_rdata),
        .m_axi_awaddr  (M_AXI_AWADDR),
        .m_axi_awprot  (M_AXI_AWPROT),
        .m_axi_awvalid (M_AXI_AWVALID),
        .m_axi_awready (M_AXI_AWREADY),
        .m_axi_wdata   (M_AXI_WDATA),
        .m_axi_wstrb   (M_AXI_WSTRB),
        .m_axi_wvalid  (M_AXI_WVALID),
        .m_axi_wready  (M_AXI_WREADY),
        .m_axi_bresp   (M_AXI_BRESP),
        .m_axi_bvalid  (M_AXI_BVALID),
        .m_axi_bready  (M_AXI_BREADY),
        .m_axi_araddr  (M_AXI_ARADDR),
        .m_axi_arprot  (M_AXI_ARPROT),
        .m_axi_arvalid (M_AXI_ARVALID),
        .m_axi_arready (M_AXI_ARREADY),
        .m_axi_rdata   (M_AXI_RDATA),
        .m_axi_rresp   (M_AXI_RRESP),
        .m_axi_rvalid  (M_AXI_RVALID),
        .m_axi_rready  (M_AXI_RREADY)
    );

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Directed bench for adder_seq_ctrl with a small AXI4-Lite adder slave model.
// The slave can stall AWREADY and inject SLVERR on B or R.
// -----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic [15:0] job_cnt;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_ADDER_BASEADDR   (BASE)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_err       (res_err),
        .busy          (busy),
        .job_cnt       (job_cnt),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;      // cycles AWVALID waits before AWREADY
    logic        berr_en  = 1'b0;   // SLVERR on writes to BASE+0
    logic        rerr_en  = 1'b0;   // SLVERR on reads
    int          aw_wait;
    logic        got_aw, got_w;
    logic [31:0] aw_q, w_q;
    logic [31:0] mem_a = '0, mem_b = '0;
    int          wr_cnt = 0, rd_cnt = 0;
    logic [31:0] wr_addr_log [16];
    logic [31:0] wr_data_log [16];
    logic [31:0] rd_addr_last = '0;
    logic        prot_bad = 1'b0;

    logic        aw_hit, w_hit, have_aw, have_w;
    logic [31:0] cur_addr, cur_data;
    logic [4:0]  axi_vld;

    assign awready  = awvalid && (aw_wait >= aw_delay);
    assign wready   = wvalid;
    assign arready  = arvalid;
    assign aw_hit   = awvalid && awready;
    assign w_hit    = wvalid && wready;
    assign have_aw  = got_aw || aw_hit;
    assign have_w   = got_w || w_hit;
    assign cur_addr = aw_hit ? awaddr : aw_q;
    assign cur_data = w_hit ? wdata : w_q;
    assign axi_vld  = {awvalid, wvalid, bready, arvalid, rready};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0;
            got_aw  <= 1'b0;
            got_w   <= 1'b0;
            aw_q    <= '0;
            w_q     <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            if ((awvalid && (awprot != 3'b000 || wstrb != 4'hF)) ||
                (arvalid && arprot != 3'b000))
                prot_bad <= 1'b1;
            if (bvalid && bready) bvalid <= 1'b0;
            if (have_aw && have_w) begin
                bvalid <= 1'b1;
                bresp  <= (berr_en && cur_addr == BASE) ? 2'b10 : 2'b00;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                wr_addr_log[wr_cnt % 16] <= cur_addr;
                wr_data_log[wr_cnt % 16] <= cur_data;
                wr_cnt <= wr_cnt + 1;
                if (cur_addr == BASE) mem_a <= cur_data;
                else if (cur_addr == BASE + 32'd4) mem_b <= cur_data;
            end else begin
                got_aw <= have_aw;
                got_w  <= have_w;
                if (aw_hit) aw_q <= awaddr;
                if (w_hit)  w_q  <= wdata;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid       <= 1'b1;
                rdata        <= (araddr == BASE + 32'd8) ? mem_a + mem_b : 32'hDEAD_BEEF;
                rresp        <= rerr_en ? 2'b10 : 2'b00;
                rd_cnt       <= rd_cnt + 1;
                rd_addr_last <= araddr;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair and wait (bounded) for res_valid.
    // lat counts clock edges from the operand handshake edge to res_valid.
    task automatic do_job(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_seen);
        @(negedge clk);
        check("op_ready_before_job", {31'd0, op_ready}, 32'd1);
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid  = 1'b0;
        lat       = 1;
        busy_seen = busy;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic       bsy;
        int         wr0, rd0, bad;
        logic [4:0] aw_pat, w_pat, b_pat;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy_err", {30'd0, busy, res_err}, 32'd0);
        check("rst_job_cnt", {16'd0, job_cnt}, 32'd0);
        check("rst_axi_vld", {27'd0, axi_vld}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_op_ready", {31'd0, op_ready}, 32'd1);

        // ---- 1 + 2, zero-wait slave ----
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_job(32'd1, 32'd2, lat, bsy);
        check("j1_latency", lat, 32'd7);
        check("j1_busy", {31'd0, bsy}, 32'd1);
        check("j1_data", res_data, 32'd3);
        check("j1_err", {31'd0, res_err}, 32'd0);
        check("j1_resp_no_vld", {27'd0, axi_vld}, 32'd0);
        check("j1_wr_cnt", wr_cnt - wr0, 32'd2);
        check("j1_wr_a_addr", wr_addr_log[wr0 % 16], BASE);
        check("j1_wr_a_data", wr_data_log[wr0 % 16], 32'd1);
        check("j1_wr_b_addr", wr_addr_log[(wr0 + 1) % 16], BASE + 32'd4);
        check("j1_wr_b_data", wr_data_log[(wr0 + 1) % 16], 32'd2);
        check("j1_rd_cnt", rd_cnt - rd0, 32'd1);
        check("j1_rd_addr", rd_addr_last, BASE + 32'd8);
        finish_job();
        check("j1_job_cnt", {16'd0, job_cnt}, 32'd1);
        check("j1_idle", {30'd0, busy, op_ready}, 32'd1);

        // ---- wrap-around sum ----
        do_job(32'hFFFF_FFFF, 32'd2, lat, bsy);
        check("j2_data", res_data, 32'd1);
        check("j2_err", {31'd0, res_err}, 32'd0);
        finish_job();
        check("j2_job_cnt", {16'd0, job_cnt}, 32'd2);

        // ---- AWREADY delayed 3 cycles, WREADY immediate ----
        aw_delay = 3;
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd8; op_valid = 1'b1;
        aw_pat = '0; w_pat = '0; b_pat = '0; bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
            aw_pat = {aw_pat[3:0], awvalid};
            w_pat  = {w_pat[3:0], wvalid};
            b_pat  = {b_pat[3:0], bready};
            if (awvalid && awaddr !== BASE) bad++;
        end
        check("dly_awvalid_pat", {27'd0, aw_pat}, 32'h1E);
        check("dly_wvalid_pat", {27'd0, w_pat}, 32'h10);
        check("dly_bready_pat", {27'd0, b_pat}, 32'h01);
        check("dly_awaddr_stable", bad, 32'd0);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("dly_res_valid", {31'd0, res_valid}, 32'd1);
        check("dly_data", res_data, 32'd15);
        finish_job();
        check("dly_job_cnt", {16'd0, job_cnt}, 32'd3);
        aw_delay = 0;

        // ---- SLVERR on the write of A ----
        berr_en = 1'b1;
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_job(32'd9, 32'd9, lat, bsy);
        check("berr_res_valid", {31'd0, res_valid}, 32'd1);
        check("berr_err", {31'd0, res_err}, 32'd1);
        check("berr_data", res_data, 32'd0);
        check("berr_wr_cnt", wr_cnt - wr0, 32'd1);
        check("berr_rd_cnt", rd_cnt - rd0, 32'd0);
        check("berr_no_vld", {27'd0, axi_vld}, 32'd0);
        finish_job();
        check("berr_job_cnt", {16'd0, job_cnt}, 32'd3);
        berr_en = 1'b0;

        // ---- SLVERR on the read of the result ----
        rerr_en = 1'b1;
        do_job(32'd3, 32'd4, lat, bsy);
        check("rerr_err", {31'd0, res_err}, 32'd1);
        check("rerr_data", res_data, 32'd7);
        finish_job();
        check("rerr_job_cnt", {16'd0, job_cnt}, 32'd3);
        rerr_en = 1'b0;

        // ---- result back-pressure for 10 cycles ----
        do_job(32'd100, 32'd23, lat, bsy);
        check("hold_first_data", res_data, 32'd123);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 32'd123 || op_ready !== 1'b0) bad++;
        end
        check("hold_stable", bad, 32'd0);
        finish_job();
        check("hold_job_cnt", {16'd0, job_cnt}, 32'd4);

        // ---- reset during WR_B while AWVALID is high ----
        aw_delay = 3;
        @(negedge clk);
        op_a = 32'd1; op_b = 32'd1; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        lat = 0;
        while (!(awvalid && awaddr == BASE + 32'd4) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("mid_reached_wr_b", {31'd0, awvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_axi_vld", {27'd0, axi_vld}, 32'd0);
        @(negedge clk);
        check("mid_rst_outputs", {res_data[15:0], job_cnt}, 32'd0);
        check("mid_rst_flags", {28'd0, op_ready, res_valid, res_err, busy}, 32'd8);
        rst_n = 1'b1;
        aw_delay = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (axi_vld !== 5'd0 || busy !== 1'b0) bad++;
        end
        check("mid_no_revalid", bad, 32'd0);
        do_job(32'd5, 32'd6, lat, bsy);
        check("mid_new_latency", lat, 32'd7);
        check("mid_new_data", res_data, 32'd11);
        check("mid_new_err", {31'd0, res_err}, 32'd0);
        finish_job();
        check("mid_job_cnt", {16'd0, job_cnt}, 32'd1);
        check("prot_strb", {31'd0, prot_bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_adder_seq_ctrl
